// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with flush, level flags and
// registered handshake pulses; one-cycle read latency on d_out.
module param_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 14,
    parameter int AE_LVL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] d_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] d_out,
    output logic [ADDR_W:0]   data_count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_C    = AF_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C    = AE_LVL[ADDR_W:0];

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR     = 3'd1,
        S_RD     = 3'd2,
        S_WR_ERR = 3'd3,
        S_RD_ERR = 3'd4,
        S_RW     = 3'd5,
        S_FLUSH  = 3'd6
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    state_t state_q, state_d;
    logic   rderr_q, rderr_d;
    logic   wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;

    logic wr_ok, rd_ok;
    logic wr_go, rd_go;

    // Level flags are decoded from the count register only.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    // A pop frees a slot on the same edge, so a full FIFO
    // still accepts a write when a read is requested.
    assign wr_ok = wr_en & (~full | rd_en);
    assign rd_ok = rd_en & ~empty;

    // Flush swallows any same-cycle request.
    assign wr_go = wr_ok & ~flush;
    assign rd_go = rd_ok & ~flush;

    // Datapath next state: pointers, count and read register.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dout_d  = '0;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr_go) begin
                tail_d = tail_q + 1'b1;
            end
            if (rd_go) begin
                head_d = head_q + 1'b1;
                dout_d = mem_q[head_q];
            end
            count_d = count_q
                    + {{ADDR_W{1'b0}}, wr_go}
                    - {{ADDR_W{1'b0}}, rd_go};
        end
    end

    // Controller next state from the requests and current count.
    always_comb begin
        state_d = S_IDLE;
        rderr_d = 1'b0;
        if (flush) begin
            state_d = S_FLUSH;
        end else if (wr_ok && rd_ok) begin
            state_d = S_RW;
        end else if (wr_ok) begin
            state_d = S_WR;
            rderr_d = rd_en;
        end else if (rd_ok) begin
            state_d = S_RD;
        end else if (wr_en) begin
            state_d = S_WR_ERR;
        end else if (rd_en) begin
            state_d = S_RD_ERR;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_go) begin
            mem_q[tail_q] <= d_in;
        end
    end

    // Pointer, count and read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    // Controller FSM with registered ack/err pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rderr_q  <= 1'b0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rderr_q  <= rderr_d;
            wr_ack_q <= (state_d == S_WR) ||
                        (state_d == S_RW);
            rd_ack_q <= (state_d == S_RD) ||
                        (state_d == S_RW);
            wr_err_q <= (state_d == S_WR_ERR);
            rd_err_q <= (state_d == S_RD_ERR) || rderr_d;
        end
    end

    assign d_out      = dout_q;
    assign data_count = count_q;
    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign rd_ack     = rd_ack_q;
    assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: default 32x16 instance
// plus an 8x8 instance for the reduced parameter set.
module tb_param_sync_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic [4:0]  data_count;
    logic        full, empty, almost_full, almost_empty;
    logic        wr_ack, wr_err, rd_ack, rd_err;

    logic        s_flush;
    logic        s_wr;
    logic        s_rd;
    logic [7:0]  s_din;
    logic [7:0]  s_dout;
    logic [3:0]  s_cnt;
    logic        s_full, s_empty, s_af, s_ae;
    logic        s_wack, s_werr, s_rack, s_rerr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_sync_fifo u_dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr_en        (wr_en),
        .d_in         (d_in),
        .rd_en        (rd_en),
        .d_out        (d_out),
        .data_count   (data_count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .rd_ack       (rd_ack),
        .rd_err       (rd_err)
    );

    param_sync_fifo #(
        .DATA_W (8),
        .ADDR_W (3),
        .AF_LVL (6),
        .AE_LVL (1)
    ) u_small (
        .clk          (clk),
        .reset        (reset),
        .flush        (s_flush),
        .wr_en        (s_wr),
        .d_in         (s_din),
        .rd_en        (s_rd),
        .d_out        (s_dout),
        .data_count   (s_cnt),
        .full         (s_full),
        .empty        (s_empty),
        .almost_full  (s_af),
        .almost_empty (s_ae),
        .wr_ack       (s_wack),
        .wr_err       (s_werr),
        .rd_ack       (s_rack),
        .rd_err       (s_rerr)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pulses(input string tag,
                              input logic wa, input logic we,
                              input logic ra, input logic re);
        chk({tag, ".wr_ack"}, {31'd0, wr_ack}, {31'd0, wa});
        chk({tag, ".wr_err"}, {31'd0, wr_err}, {31'd0, we});
        chk({tag, ".rd_ack"}, {31'd0, rd_ack}, {31'd0, ra});
        chk({tag, ".rd_err"}, {31'd0, rd_err}, {31'd0, re});
    endtask

    task automatic push(input logic [31:0] v);
        wr_en = 1'b1;
        rd_en = 1'b0;
        d_in  = v;
        tick();
        chk("push.wr_ack", {31'd0, wr_ack}, 32'd1);
        wr_en = 1'b0;
    endtask

    task automatic pop(input logic [31:0] v);
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        chk("pop.rd_ack", {31'd0, rd_ack}, 32'd1);
        chk("pop.d_out", d_out, v);
        rd_en = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        d_in    = 32'hDEAD_BEEF;
        s_flush = 1'b0;
        s_wr    = 1'b0;
        s_rd    = 1'b0;
        s_din   = 8'h00;

        // T1 reset with requests active
        tick();
        tick();
        chk("t1.count", {27'd0, data_count}, 32'd0);
        chk("t1.empty", {31'd0, empty}, 32'd1);
        chk("t1.full", {31'd0, full}, 32'd0);
        chk("t1.ae", {31'd0, almost_empty}, 32'd1);
        chk("t1.af", {31'd0, almost_full}, 32'd0);
        chk("t1.d_out", d_out, 32'd0);
        chk_pulses("t1", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        chk_pulses("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // T2 fill
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            d_in  = 32'hA000_0000 + i;
            tick();
            chk_pulses("t2.wr", 1'b1, 1'b0, 1'b0, 1'b0);
            chk("t2.count", {27'd0, data_count}, i + 1);
            chk("t2.af", {31'd0, almost_full},
                {31'd0, (i + 1) >= 14});
            chk("t2.ae", {31'd0, almost_empty},
                {31'd0, (i + 1) <= 2});
            chk("t2.full", {31'd0, full},
                {31'd0, (i + 1) == 16});
        end
        d_in = 32'h1234_5678;
        tick();
        chk_pulses("t2.wr17", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2.cnt17", {27'd0, data_count}, 32'd16);
        wr_en = 1'b0;
        tick();
        chk_pulses("t2.gap", 1'b0, 1'b0, 1'b0, 1'b0);

        // T2 drain
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            chk_pulses("t2.rd", 1'b0, 1'b0, 1'b1, 1'b0);
            chk("t2.d_out", d_out, 32'hA000_0000 + i);
            chk("t2.dcnt", {27'd0, data_count}, 15 - i);
        end
        tick();
        chk_pulses("t2.rd17", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2.d_out17", d_out, 32'd0);
        chk("t2.empty", {31'd0, empty}, 32'd1);
        rd_en = 1'b0;
        tick();
        chk("t2.rerr_pulse", {31'd0, rd_err}, 32'd0);

        // T3 wrap
        for (int i = 0; i < 10; i++) push(32'hB000_0000 + i);
        for (int i = 0; i < 10; i++) pop(32'hB000_0000 + i);
        for (int i = 0; i < 12; i++) push(32'hC000_0000 + i);
        chk("t3.count12", {27'd0, data_count}, 32'd12);
        for (int i = 0; i < 12; i++) pop(32'hC000_0000 + i);
        chk("t3.count0", {27'd0, data_count}, 32'd0);

        // T4 read+write on full
        for (int i = 0; i < 16; i++) push(32'hD000_0000 + i);
        wr_en = 1'b1;
        rd_en = 1'b1;
        d_in  = 32'hE000_0000;
        tick();
        chk_pulses("t4.full_rw", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4.count", {27'd0, data_count}, 32'd16);
        chk("t4.d_out", d_out, 32'hD000_0000);
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 1; i < 16; i++) pop(32'hD000_0000 + i);
        pop(32'hE000_0000);
        chk("t4.empty", {31'd0, empty}, 32'd1);

        // T4 read+write on empty
        wr_en = 1'b1;
        rd_en = 1'b1;
        d_in  = 32'hF000_00F0;
        tick();
        chk_pulses("t4.empty_rw", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4.ecount", {27'd0, data_count}, 32'd1);
        chk("t4.ed_out", d_out, 32'd0);
        wr_en = 1'b0;
        rd_en = 1'b0;
        pop(32'hF000_00F0);
        chk("t4.ecount0", {27'd0, data_count}, 32'd0);

        // T5 flush
        for (int i = 0; i < 7; i++) push(32'h7700_0000 + i);
        chk("t5.count7", {27'd0, data_count}, 32'd7);
        flush = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        d_in  = 32'h0000_00AA;
        tick();
        chk("t5.count", {27'd0, data_count}, 32'd0);
        chk("t5.empty", {31'd0, empty}, 32'd1);
        chk("t5.d_out", d_out, 32'd0);
        chk_pulses("t5", 1'b0, 1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        push(32'h0000_0055);
        pop(32'h0000_0055);

        // T6 small instance
        for (int i = 0; i < 8; i++) begin
            s_wr  = 1'b1;
            s_din = 8'h10 + 8'(i);
            tick();
            chk("t6.wack", {31'd0, s_wack}, 32'd1);
            chk("t6.cnt", {28'd0, s_cnt}, i + 1);
            chk("t6.full", {31'd0, s_full},
                {31'd0, (i + 1) == 8});
            chk("t6.af", {31'd0, s_af},
                {31'd0, (i + 1) >= 6});
            chk("t6.ae", {31'd0, s_ae},
                {31'd0, (i + 1) <= 1});
        end
        s_din = 8'hFF;
        tick();
        chk("t6.werr", {31'd0, s_werr}, 32'd1);
        s_wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_rd = 1'b1;
            tick();
            chk("t6.rack", {31'd0, s_rack}, 32'd1);
            chk("t6.dout", {24'd0, s_dout}, 32'h10 + i);
            chk("t6.rcnt", {28'd0, s_cnt}, 7 - i);
            chk("t6.rae", {31'd0, s_ae},
                {31'd0, (7 - i) <= 1});
        end
        tick();
        chk("t6.rerr", {31'd0, s_rerr}, 32'd1);
        chk("t6.empty", {31'd0, s_empty}, 32'd1);
        s_rd = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
